// File: rtl/hazard_scheduler.sv
// Scoreboard-based issue scheduler for the decode stage: per-register writeback timers gate issue,
// drive freeze/bubble/if_flush, and count stall cycles. Optional macro: FORWARDING_EN.
module hazard_scheduler #(
  parameter int unsigned WB_LATENCY = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_uses_src2,
  input  logic [4:0]       id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             br_taken,
  output logic             freeze,
  output logic             bubble,
  output logic             if_flush,
  output logic             issue,
  output logic             sb_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] LAT_VAL = 3'(WB_LATENCY);

  logic [2:0]  timer [1:31];
  logic [31:0] pend_vec;
  logic        hazard;
  logic        set_en;
  logic [2:0]  load_val;

  // r0 is hardwired as never pending, so it needs no timer storage.
  always_comb begin
    pend_vec    = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      pend_vec[r] = (timer[r] != '0);
    end
  end

  always_comb begin
    hazard = id_valid & (pend_vec[id_src1] | (id_uses_src2 & pend_vec[id_src2]));
  end

  always_comb begin
    freeze   = 1'b0;
    bubble   = 1'b0;
    if_flush = 1'b0;
    issue    = 1'b0;
    if (br_taken) begin
      if_flush = 1'b1;
      bubble   = 1'b1;
    end else if (hazard) begin
      freeze   = 1'b1;
      bubble   = 1'b1;
    end else begin
      issue    = id_valid;
    end
  end

`ifdef FORWARDING_EN
  // Only loads need a scoreboard entry; everything else is covered by forwarding.
  always_comb begin
    set_en   = issue & id_wb_en & id_mem_r_en;
    load_val = 3'd1;
  end
`else
  logic unused_mem_r_en;
  assign unused_mem_r_en = id_mem_r_en;

  always_comb begin
    set_en   = issue & id_wb_en;
    load_val = LAT_VAL;
  end
`endif

  // A fresh issue to a register reloads its timer; all others drain regardless of stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 1; r < 32; r++) begin
        timer[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (set_en && (id_dest == 5'(r))) begin
          timer[r] <= load_val;
        end else if (timer[r] != '0) begin
          timer[r] <= timer[r] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (freeze && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    sb_busy = |pend_vec;
  end

  a_flush_not_freeze: assert property (@(posedge clk) disable iff (!rst) !(if_flush && freeze));
  a_issue_no_bubble:  assert property (@(posedge clk) disable iff (!rst) !(issue && bubble));

endmodule
